// File: rtl/vein_pkg.sv
// Shared definitions for the vein frame sequencer: state encoding, default
// sizing and a width helper used by the top level.
package vein_pkg;

  localparam int IMG_PIX_DEF  = 3072;
  localparam int RES_N_DEF    = 256;
  localparam int ADDR_W_DEF   = 12;
  localparam int CONV_TMO_DEF = 4095;
  localparam int FRAME_CNT_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SAVE       = 3'd1,
    ST_CONV_START = 3'd2,
    ST_CONV_WAIT  = 3'd3,
    ST_SEND       = 3'd4,
    ST_DONE       = 3'd5
  } state_e;

  // Bits needed to hold any value in 0..max_val (never less than one).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/seq_counter.sv
// Generic up-counter with synchronous clear, count enable and a terminal-count
// flag; it wraps to zero when enabled at MAX.
module seq_counter #(
  parameter int W   = 8,
  parameter int MAX = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         at_max
);

  assign at_max = (count == W'(MAX));

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values; blocking assignments here would create order-dependent
  // behaviour between processes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= at_max ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/vein_frame_sequencer.sv
// Frame sequencer: captures one sensor frame, launches the convolution engine,
// then streams the result buffer downstream with a valid/ready handshake.
module vein_frame_sequencer
  import vein_pkg::*;
#(
  parameter int IMG_PIX  = IMG_PIX_DEF,
  parameter int RES_N    = RES_N_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int CONV_TMO = CONV_TMO_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   trigger,
  input  logic                   abort,
  input  logic                   pix_valid,
  output logic                   wr_en,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic                   conv_start,
  input  logic                   conv_done,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [ADDR_W-1:0]      tx_addr,
  output logic                   busy,
  output logic                   err,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int TMO_W = cnt_width(CONV_TMO);

  state_e           state;
  state_e           state_nxt;
  logic             start_frame;
  logic             tx_accept;
  logic             tmo_tick;
  logic             tmo_expired;
  logic             wr_last;
  logic             tx_last;
  logic             tmo_last;
  logic [TMO_W-1:0] tmo_cnt_unused;

  // Abort outranks trigger, so a simultaneous pair leaves the frame unstarted.
  assign start_frame = (state == ST_IDLE) && trigger && !abort;
  assign tx_accept   = tx_valid && tx_ready;
  assign tmo_tick    = (state == ST_CONV_WAIT) && !conv_done;
  // Terminal at CONV_TMO-1: the tick that would reach CONV_TMO is the timeout.
  assign tmo_expired = tmo_tick && tmo_last;
  assign busy        = (state != ST_IDLE);

  seq_counter #(
    .W   (ADDR_W),
    .MAX (IMG_PIX - 1)
  ) u_wr_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (start_frame),
    .en     (wr_en),
    .count  (wr_addr),
    .at_max (wr_last)
  );

  seq_counter #(
    .W   (ADDR_W),
    .MAX (RES_N - 1)
  ) u_tx_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (start_frame),
    .en     (tx_accept),
    .count  (tx_addr),
    .at_max (tx_last)
  );

  // Only the terminal flag of the timeout counter drives any decision.
  seq_counter #(
    .W   (TMO_W),
    .MAX (CONV_TMO - 1)
  ) u_tmo_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (start_frame),
    .en     (tmo_tick),
    .count  (tmo_cnt_unused),
    .at_max (tmo_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt  = state;
    wr_en      = 1'b0;
    conv_start = 1'b0;
    tx_valid   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (trigger) state_nxt = ST_SAVE;
      end
      ST_SAVE: begin
        wr_en = pix_valid;
        if (pix_valid && wr_last) state_nxt = ST_CONV_START;
      end
      ST_CONV_START: begin
        conv_start = 1'b1;
        state_nxt  = ST_CONV_WAIT;
      end
      ST_CONV_WAIT: begin
        if (conv_done)     state_nxt = ST_SEND;
        else if (tmo_last) state_nxt = ST_IDLE;
      end
      ST_SEND: begin
        tx_valid = 1'b1;
        if (tx_ready && tx_last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    if (abort) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err       <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (start_frame) begin
        err <= 1'b0;
      end else if (tmo_expired && !abort) begin
        err <= 1'b1;
      end
      if ((state == ST_DONE) && !abort) begin
        frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/vein_frame_sequencer.md
VEIN_FRAME_SEQUENCER -- requirements
Module: vein_frame_sequencer

Interface
REQ-001 Parameter IMG_PIX, default 3072, pixels per captured frame (>=2).
REQ-002 Parameter RES_N, default 256, result words per frame to transmit (>=1).
REQ-003 Parameter ADDR_W, default 12, width of both address buses; must satisfy 2^ADDR_W >= max(IMG_PIX, RES_N).
REQ-004 Parameter CONV_TMO, default 4095, maximum cycles to wait for conv_done.
REQ-005 Clocking: one clock. Reset is asynchronous and active-high.
REQ-006 Port clk, input, 1, rising-edge system clock.
REQ-007 Port rst, input, 1, asynchronous active-high reset.
REQ-008 Port trigger, input, 1, frame request, sampled in IDLE.
REQ-009 Port abort, input, 1, synchronous return to IDLE from any state.
REQ-010 Port pix_valid, input, 1, sensor pixel present this cycle.
REQ-011 Port wr_en, output, 1, frame buffer write strobe.
REQ-012 Port wr_addr, output, ADDR_W, frame buffer write address.
REQ-013 Port conv_start, output, 1, one-cycle pulse that launches the convolution engine.
REQ-014 Port conv_done, input, 1, engine completion pulse.
REQ-015 Port tx_valid, output, 1, result word at tx_addr is offered downstream.
REQ-016 Port tx_ready, input, 1, downstream accepts.
REQ-017 Port tx_addr, output, ADDR_W, result buffer read address.
REQ-018 Port busy, output, 1, high in every state except IDLE.
REQ-019 Port err, output, 1, sticky convolution timeout flag.
REQ-020 Port frame_cnt, output, 8, count of completed frames.

Function
REQ-021 The state set SHALL be IDLE, SAVE, CONV_START, CONV_WAIT, SEND, DONE; state, counters and flags are registered, and outputs decode from registered state.
REQ-022 In IDLE with trigger=1, the next state SHALL be SAVE; wr_addr, tx_addr and the timeout counter SHALL clear to 0, and err SHALL clear.
REQ-023 In SAVE, wr_en SHALL equal pix_valid combinationally; wr_addr SHALL increment by 1 per accepted pixel. When a pixel is accepted at wr_addr=IMG_PIX-1, the next state SHALL be CONV_START, and wr_addr SHALL wrap to 0.
REQ-024 pix_valid outside SAVE SHALL be ignored (wr_en=0).
REQ-025 CONV_START SHALL last exactly 1 cycle with conv_start=1, then go to CONV_WAIT; conv_done in CONV_START SHALL be ignored.
REQ-026 In CONV_WAIT, conv_done=1 SHALL go to SEND. Otherwise the timeout counter increments each cycle; when it reaches CONV_TMO without conv_done, the block SHALL set err=1 and go to IDLE, with no frame_cnt increment.
REQ-027 In SEND, tx_valid SHALL be 1 and tx_addr SHALL hold until tx_valid&&tx_ready. On acceptance tx_addr increments. Acceptance at tx_addr=RES_N-1 SHALL go to DONE, and tx_addr wraps to 0.
REQ-028 tx_ready held low SHALL stall SEND indefinitely; this is not an error.
REQ-029 DONE SHALL last 1 cycle, increment frame_cnt (wraps 255->0), then go to IDLE.
REQ-030 trigger outside IDLE SHALL be ignored and SHALL NOT be queued.
REQ-031 abort=1 in any non-IDLE state SHALL go to IDLE next cycle with no frame_cnt change and err unchanged. abort SHALL have priority over every other transition. abort and trigger asserted together in IDLE SHALL remain in IDLE.
REQ-032 conv_start, wr_en and tx_valid SHALL never be asserted in the same cycle.

Reset
REQ-033 rst=1 SHALL force state IDLE and set wr_addr=0, tx_addr=0, timeout counter=0, err=0, frame_cnt=0, with all strobes 0.
REQ-034 Reset asserted mid-frame SHALL discard progress; the first trigger after release starts a fresh frame at address 0.

Structure
REQ-035 The state encoding and the default parameter values SHALL be defined in a shared package, vein_pkg.
REQ-036 The generic up-counter with clear, enable and terminal-count compare SHALL be one sub-module, seq_counter. It is instantiated for wr_addr, tx_addr and the timeout counter.

Verification
(Overrides: IMG_PIX=8, RES_N=3, CONV_TMO=10.)
REQ-037 Nominal frame: trigger; 8 pix_valid; conv_done 5 cycles after conv_start; tx_ready=1 -> wr_addr 0..7; conv_start pulses exactly once; tx_addr 0,1,2; frame_cnt=1; busy falls.
REQ-038 Gapped pixels: pix_valid every 3rd cycle -> exactly 8 writes; conv_start only after the 8th write.
REQ-039 Timeout: conv_done never asserted -> err=1 after 10 CONV_WAIT cycles; state IDLE; frame_cnt unchanged; next trigger clears err.
REQ-040 Backpressure: tx_ready low 20 cycles, then alternating -> tx_addr stable while stalled; exactly 3 handshakes.
REQ-041 Abort during SAVE at wr_addr=4, then a new trigger -> IDLE; wr_addr restarts at 0; frame_cnt unchanged; no conv_start.
REQ-042 Async rst asserted mid-SEND without a clock edge -> all outputs at reset values immediately; trigger during busy has no effect.
